// File: rtl/jk_excitation_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jk_excitation_driver - drives J/K of an external JK bank toward a target word
// and verifies the Q readback.                                      Rev 1.0
// ---------------------------------------------------------------------------
module jk_excitation_driver #(
   parameter int WIDTH       = 4,
   parameter int TOGGLE_MODE = 0,
   parameter int SETTLE      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_data,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             ff_en,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] err_mask,
   output logic [7:0]       xfer_count,
   output logic [7:0]       err_count
);

   localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_DRIVE       = 2'd1,
      S_SETTLE_WAIT = 2'd2,
      S_CHECK       = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_tgt;
   logic [WIDTH-1:0] r_j;
   logic [WIDTH-1:0] r_k;
   logic [3:0]       r_settle_cnt;
   logic [WIDTH-1:0] r_err_mask;
   logic [7:0]       r_xfer;
   logic [7:0]       r_errc;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic             w_accept;

   generate
      if (TOGGLE_MODE != 0) begin : g_toggle
         assign w_j = tgt_data ^ q_in;
         assign w_k = tgt_data ^ q_in;
      end else begin : g_setreset
         // Don't-care terms resolved to 0 so J=K=1 can never be driven.
         assign w_j = tgt_data & ~q_in;
         assign w_k = q_in & ~tgt_data;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      tgt_ready = 1'b0;
      ff_en     = 1'b0;
      done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            tgt_ready = ~rst;
            if (tgt_valid) begin
               w_next = S_DRIVE;
            end
         end
         S_DRIVE: begin
            ff_en  = 1'b1;
            w_next = S_SETTLE_WAIT;
         end
         S_SETTLE_WAIT: begin
            if (r_settle_cnt == 4'd0) begin
               w_next = S_CHECK;
            end
         end
         S_CHECK: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_accept = tgt_valid & tgt_ready;
   assign err      = done & (q_in != r_tgt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tgt        <= '0;
         r_j          <= '0;
         r_k          <= '0;
         r_settle_cnt <= 4'd0;
         r_err_mask   <= '0;
         r_xfer       <= 8'd0;
         r_errc       <= 8'd0;
      end else begin
         // Excitation is captured at accept so it is presented only during DRIVE.
         r_j <= w_accept ? w_j : '0;
         r_k <= w_accept ? w_k : '0;
         if (w_accept) begin
            r_tgt <= tgt_data;
         end
         if (r_state == S_DRIVE) begin
            r_settle_cnt <= C_SETTLE_LOAD;
         end else if (r_state == S_SETTLE_WAIT && r_settle_cnt != 4'd0) begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
         end
         if (r_state == S_CHECK) begin
            r_err_mask <= q_in ^ r_tgt;
            r_xfer     <= r_xfer + 8'd1;
            if (err && r_errc != 8'hFF) begin
               r_errc <= r_errc + 8'd1;
            end
         end
      end
   end

   assign j_out      = r_j;
   assign k_out      = r_k;
   assign err_mask   = r_err_mask;
   assign xfer_count = r_xfer;
   assign err_count  = r_errc;

endmodule
`default_nettype wire

// File: tb/tb_jk_excitation_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_jk_excitation_driver - two driver instances (set/reset SETTLE=1, toggle
// SETTLE=4) each driving a behavioural JK bank.                     Rev 1.0
// ---------------------------------------------------------------------------
module tb_jk_excitation_driver;

   localparam int W  = 4;
   localparam int S0 = 1;
   localparam int S1 = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   v;
   logic [W-1:0] d     [2];
   logic [W-1:0] bq    [2];
   logic [W-1:0] stuck [2];

   wire  [1:0]   rdy, ffen, dn, er;
   wire  [W-1:0] jo [2];
   wire  [W-1:0] ko [2];
   wire  [W-1:0] em [2];
   wire  [7:0]   xo [2];
   wire  [7:0]   eo [2];

   int           n_cmp = 0;
   int           n_mis = 0;
   int           mx [2];
   int           me [2];
   logic [W-1:0] mm [2];
   longint       last_acc [2];

   always #5 clk = ~clk;

   jk_excitation_driver #(.WIDTH(W), .TOGGLE_MODE(0), .SETTLE(S0)) u_sr (
      .clk(clk), .rst(rst), .tgt_valid(v[0]), .tgt_ready(rdy[0]), .tgt_data(d[0]),
      .q_in(bq[0]), .j_out(jo[0]), .k_out(ko[0]), .ff_en(ffen[0]), .done(dn[0]),
      .err(er[0]), .err_mask(em[0]), .xfer_count(xo[0]), .err_count(eo[0])
   );

   jk_excitation_driver #(.WIDTH(W), .TOGGLE_MODE(1), .SETTLE(S1)) u_tg (
      .clk(clk), .rst(rst), .tgt_valid(v[1]), .tgt_ready(rdy[1]), .tgt_data(d[1]),
      .q_in(bq[1]), .j_out(jo[1]), .k_out(ko[1]), .ff_en(ffen[1]), .done(dn[1]),
      .err(er[1]), .err_mask(em[1]), .xfer_count(xo[1]), .err_count(eo[1])
   );

   // JK bank: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits.
   always @(posedge clk or posedge rst) begin
      for (int u = 0; u < 2; u++) begin
         if (rst) bq[u] <= '0;
         else if (ffen[u]) bq[u] <= ((jo[u] & ~bq[u]) | (~ko[u] & bq[u])) & ~stuck[u];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Excitation table from the per-bit rules.
   task automatic ref_jk(input bit tog, input logic [W-1:0] c, input logic [W-1:0] t,
                         output logic [W-1:0] j, output logic [W-1:0] k);
      j = '0;
      k = '0;
      for (int b = 0; b < W; b++) begin
         if (c[b] != t[b]) begin
            if (tog) begin
               j[b] = 1'b1;
               k[b] = 1'b1;
            end else if (t[b]) begin
               j[b] = 1'b1;
            end else begin
               k[b] = 1'b1;
            end
         end
      end
   endtask

   task automatic do_reset();
      v   = '0;
      rst = 1'b1;
      #1;
      for (int u = 0; u < 2; u++) begin
         chk("rst_ready", rdy[u], 0);
         chk("rst_ffen", ffen[u], 0);
         chk("rst_done", dn[u], 0);
         chk("rst_err", er[u], 0);
         chk("rst_j", jo[u], 0);
         chk("rst_k", ko[u], 0);
         chk("rst_mask", em[u], 0);
         chk("rst_xfer", xo[u], 0);
         chk("rst_errc", eo[u], 0);
         mx[u] = 0;
         me[u] = 0;
         mm[u] = '0;
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk("post_rst_ready", rdy[u], 1);
         chk("post_rst_done", dn[u], 0);
      end
   endtask

   // Entered and left at a negedge with unit u idle.
   task automatic xfer(input int u, input logic [W-1:0] t, input bit hold,
                       input logic [W-1:0] nxt, input bit chk_gap);
      logic [W-1:0] c, ej, ek, eq;
      int           s;
      longint       now;
      s    = (u == 0) ? S0 : S1;
      v[u] = 1'b1;
      d[u] = t;
      c    = bq[u];
      chk("idle_ready", rdy[u], 1);
      chk("idle_j", jo[u], 0);
      now = $time;
      if (chk_gap) chk("b2b_gap", 32'((now - last_acc[u]) / 10), s + 3);
      last_acc[u] = now;
      ref_jk(u == 1, c, t, ej, ek);
      eq = t & ~stuck[u];
      @(negedge clk);
      chk("drive_ffen", ffen[u], 1);
      chk("drive_j", jo[u], ej);
      chk("drive_k", ko[u], ek);
      chk("drive_ready", rdy[u], 0);
      chk("drive_done", dn[u], 0);
      if (hold) d[u] = nxt;
      else v[u] = 1'b0;
      repeat (s) begin
         @(negedge clk);
         chk("wait_ffen", ffen[u], 0);
         chk("wait_done", dn[u], 0);
         chk("wait_jk", {jo[u], ko[u]}, 0);
         chk("wait_ready", rdy[u], 0);
      end
      @(negedge clk);
      mx[u] = (mx[u] + 1) % 256;
      if (eq != t && me[u] < 255) me[u]++;
      mm[u] = eq ^ t;
      chk("check_done", dn[u], 1);
      chk("check_err", er[u], (eq != t) ? 1 : 0);
      chk("check_ready", rdy[u], 0);
      chk("check_ffen", ffen[u], 0);
      @(negedge clk);
      chk("after_done", dn[u], 0);
      chk("after_err", er[u], 0);
      chk("after_mask", em[u], mm[u]);
      chk("after_xfer", xo[u], mx[u]);
      chk("after_errc", eo[u], me[u]);
      chk("after_ready", rdy[u], 1);
   endtask

   initial begin
      rst      = 1'b0;
      v        = '0;
      d[0]     = '0;
      d[1]     = '0;
      stuck[0] = '0;
      stuck[1] = '0;
      @(negedge clk);
      do_reset();

      // Directed: 0000->1010, ->1111, ->0110 (0110 from 1111 exercises K)
      for (int u = 0; u < 2; u++) begin
         xfer(u, 4'b1010, 1'b0, '0, 1'b0);
         xfer(u, 4'b1111, 1'b0, '0, 1'b0);
         xfer(u, 4'b0110, 1'b0, '0, 1'b0);
         xfer(u, 4'b0110, 1'b0, '0, 1'b0);
      end
      chk("sr_xfer4", xo[0], 4);
      chk("tg_xfer4", xo[1], 4);

      // Random targets
      for (int i = 0; i < 25; i++) begin
         xfer(0, W'($urandom), 1'b0, '0, 1'b0);
         xfer(1, W'($urandom), 1'b0, '0, 1'b0);
      end

      // Back-to-back with tgt_valid held high
      for (int u = 0; u < 2; u++) begin
         xfer(u, 4'b0000, 1'b0, '0, 1'b0);
         xfer(u, 4'b0001, 1'b1, 4'b0011, 1'b0);
         xfer(u, 4'b0011, 1'b0, '0, 1'b1);
      end

      // Reset during SETTLE_WAIT aborts the transfer
      v[0] = 1'b1;
      d[0] = 4'b1001;
      @(negedge clk);
      v[0] = 1'b0;
      @(negedge clk);
      chk("abort_in_wait", ffen[0], 0);
      do_reset();
      xfer(0, 4'b1001, 1'b0, '0, 1'b0);
      chk("abort_then_xfer", xo[0], 1);

      // Stuck-at-0 bit 2: saturation of err_count, wrap of xfer_count
      do_reset();
      stuck[0] = 4'b0100;
      for (int i = 0; i < 260; i++) xfer(0, 4'b0100, 1'b0, '0, 1'b0);
      chk("stuck_mask", em[0], 4'b0100);
      chk("stuck_errc_sat", eo[0], 255);
      chk("stuck_xfer_wrap", xo[0], 4);
      stuck[0] = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
